// File: rtl/exec_mem_unit.sv
// ---------------------------------------------------------------------------
// exec_mem_unit
//
// Execute/memory datapath slice of a 5-stage RV32I pipeline:
//   * ALU control decoder  (combinational)
//   * 32-bit ALU with zero flag (combinational)
//   * word-addressed data memory: synchronous write, combinational read
//
// Optional feature macro: ALU_XOR_EN
//   defined   -> alu_op 10 / funct3 100 decodes to control 100, which computes a^b
//   undefined -> funct3 100 decodes to add (000); control 100 yields 0
//
// Parameters:
//   DEPTH      number of 32-bit words in data memory (power of two, >= 4)
//   ADDR_BITS  word-index width, derived from DEPTH
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous active-high, clears data memory
//   alu_op       in   2   00 add, 01 sub, 10 decode funct3, 11 reserved (add)
//   funct3       in   3   instruction bits [14:12]
//   op5          in   1   instruction bit [5] (1 = R-type)
//   funct7_5     in   1   instruction bit [30]
//   src_a        in   32  ALU operand A
//   src_b        in   32  ALU operand B
//   alu_control  out  3   decoded ALU operation
//   alu_result   out  32  ALU result
//   zero         out  1   1 when alu_result == 0
//   mem_we       in   1   data memory write enable
//   mem_adr      in   32  byte address (word-aligned, wraps modulo DEPTH*4)
//   mem_wd       in   32  write data
//   mem_rd       out  32  read data (old data during a same-cycle write)
// ---------------------------------------------------------------------------
module exec_mem_unit #(
    parameter  int DEPTH     = 64,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [2:0]  funct3,
    input  logic        op5,
    input  logic        funct7_5,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [2:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    input  logic        mem_we,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_wd,
    output logic [31:0] mem_rd
);

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_AND = 3'b010;
    localparam logic [2:0] CTRL_OR  = 3'b011;
    localparam logic [2:0] CTRL_XOR = 3'b100;
    localparam logic [2:0] CTRL_SLT = 3'b101;

    // ------------------------------------------------------------------
    // ALU control decoder
    // ------------------------------------------------------------------
    logic [2:0] w_alu_control;

    always_comb begin
        w_alu_control = CTRL_ADD;
        case (alu_op)
            2'b00: w_alu_control = CTRL_ADD;
            2'b01: w_alu_control = CTRL_SUB;
            2'b10: begin
                case (funct3)
                    // Only R-type (op5=1) with bit30 set is a subtract;
                    // addi with bit30=1 stays an add.
                    3'b000:  w_alu_control = ({op5, funct7_5} == 2'b11) ? CTRL_SUB : CTRL_ADD;
                    3'b010:  w_alu_control = CTRL_SLT;
                    3'b110:  w_alu_control = CTRL_OR;
                    3'b111:  w_alu_control = CTRL_AND;
`ifdef ALU_XOR_EN
                    3'b100:  w_alu_control = CTRL_XOR;
`endif
                    default: w_alu_control = CTRL_ADD;
                endcase
            end
            default: w_alu_control = CTRL_ADD;
        endcase
    end

    assign alu_control = w_alu_control;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic        [31:0] w_alu_result;

    assign w_a_s = src_a;
    assign w_b_s = src_b;

    always_comb begin
        w_alu_result = 32'd0;
        case (w_alu_control)
            CTRL_ADD: w_alu_result = src_a + src_b;
            CTRL_SUB: w_alu_result = src_a - src_b;
            CTRL_AND: w_alu_result = src_a & src_b;
            CTRL_OR:  w_alu_result = src_a | src_b;
            CTRL_SLT: w_alu_result = (w_a_s < w_b_s) ? 32'd1 : 32'd0;
`ifdef ALU_XOR_EN
            CTRL_XOR: w_alu_result = src_a ^ src_b;
`endif
            // Unused codes produce 0 so zero reads 1.
            default:  w_alu_result = 32'd0;
        endcase
    end

    assign alu_result = w_alu_result;
    assign zero       = (w_alu_result == 32'd0);

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [31:0]          r_mem [DEPTH];
    logic [ADDR_BITS-1:0] w_index;
    logic                 w_unused_adr_bits;

    // Byte-offset bits and bits above the array size are dropped, so the
    // access is word-aligned and wraps modulo DEPTH*4.
    assign w_index           = mem_adr[ADDR_BITS+1:2];
    assign w_unused_adr_bits = ^{mem_adr[31:ADDR_BITS+2], mem_adr[1:0]};

    // Reset wins over a concurrent write and clears every word in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (mem_we) begin
            r_mem[w_index] <= mem_wd;
        end
    end

    // Combinational read: a same-cycle write shows up only after the edge.
    assign mem_rd = r_mem[w_index];

endmodule

// File: tb/tb_exec_mem_unit.sv
module tb_exec_mem_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        op5;
    logic        funct7_5;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    exec_mem_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .op5        (op5),
        .funct7_5   (funct7_5),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_control(alu_control),
        .alu_result (alu_result),
        .zero       (zero),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                            input logic o5, input logic f7);
        if (op == 2'd1) return 3'd1;
        if (op != 2'd2) return 3'd0;
        if (f3 == 3'd0) return (o5 && f7) ? 3'd1 : 3'd0;
        if (f3 == 3'd2) return 3'd5;
        if (f3 == 3'd6) return 3'd3;
        if (f3 == 3'd7) return 3'd2;
`ifdef ALU_XOR_EN
        if (f3 == 3'd4) return 3'd4;
`endif
        return 3'd0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (c == 3'd0) return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
        if (c == 3'd1) return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
        if (c == 3'd2) return a & b;
        if (c == 3'd3) return a | b;
        if (c == 3'd5) return (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_XOR_EN
        if (c == 3'd4) return a ^ b;
`endif
        return 32'd0;
    endfunction

    function automatic int ref_idx(input logic [31:0] adr);
        return int'((adr / 4) % DEPTH);
    endfunction

    // Drive-only helper: one clocked write, model updated after the edge.
    task automatic do_write(input logic [31:0] adr, input logic [31:0] wd);
        @(negedge clk);
        mem_we  = 1'b1;
        mem_adr = adr;
        mem_wd  = wd;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        ref_mem[ref_idx(adr)] = wd;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_r;
        logic [2:0]  exp_c;
        logic [31:0] probe [4];
        @(negedge clk);
        reset    = 1'b1;
        mem_we   = 1'b1;
        mem_adr  = $urandom;
        mem_wd   = $urandom;
        alu_op   = 2'b10;
        funct3   = 3'b000;
        op5      = 1'b1;
        funct7_5 = 1'b1;
        src_a    = 32'd5;
        src_b    = 32'd7;
        #1;
        exp_c = ref_ctrl(alu_op, funct3, op5, funct7_5);
        exp_r = ref_alu(exp_c, src_a, src_b);
        checks++;
        if (alu_control !== exp_c || alu_result !== exp_r) begin
            errors++;
            $display("FAIL reset_alu_live ctrl=%h res=%h expected ctrl=%h res=%h",
                     alu_control, alu_result, exp_c, exp_r);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        @(negedge clk);
        reset  = 1'b0;
        mem_we = 1'b0;
        probe[0] = 32'd0;
        probe[1] = 32'd4;
        probe[2] = 32'd252;
        probe[3] = $urandom;
        for (int i = 0; i < 4; i++) begin
            mem_adr = probe[i];
            #1;
            checks++;
            if (mem_rd !== 32'd0) begin
                errors++;
                $display("FAIL reset_read adr=%h got=%h expected=00000000", probe[i], mem_rd);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        mem_we  = 1'b1;
        mem_adr = 32'd8;
        mem_wd  = 32'hDEADBEEF;
        #1;
        checks++;
        if (mem_rd !== ref_mem[ref_idx(32'd8)]) begin
            errors++;
            $display("FAIL write_old_data got=%h expected=%h", mem_rd, ref_mem[ref_idx(32'd8)]);
        end
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        ref_mem[ref_idx(32'd8)] = 32'hDEADBEEF;
        checks++;
        if (mem_rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_new_data got=%h expected=deadbeef", mem_rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] adrs [2];
        do_write(32'h100, 32'h12345678);
        adrs[0] = 32'd0;
        adrs[1] = 32'd3;
        for (int i = 0; i < 2; i++) begin
            mem_adr = adrs[i];
            #1;
            checks++;
            if (mem_rd !== ref_mem[ref_idx(adrs[i])] || mem_rd !== 32'h12345678) begin
                errors++;
                $display("FAIL wrap adr=%h got=%h expected=12345678", adrs[i], mem_rd);
            end
        end
    endtask

    task automatic test_decoder();
        // {alu_op, funct3, op5, funct7_5, expected control}
        logic [9:0] vec [8];
        logic [2:0] exp_c;
        vec[0] = {2'b10, 3'b000, 2'b11, 3'b001};
        vec[1] = {2'b10, 3'b000, 2'b01, 3'b000};
        vec[2] = {2'b10, 3'b010, 2'b00, 3'b101};
        vec[3] = {2'b10, 3'b110, 2'b00, 3'b011};
        vec[4] = {2'b10, 3'b111, 2'b00, 3'b010};
        vec[5] = {2'b01, 3'b000, 2'b00, 3'b001};
        vec[6] = {2'b00, 3'b111, 2'b11, 3'b000};
        vec[7] = {2'b11, 3'b010, 2'b11, 3'b000};
        for (int i = 0; i < 8; i++) begin
            {alu_op, funct3, op5, funct7_5} = vec[i][9:3];
            #1;
            checks++;
            if (alu_control !== vec[i][2:0]) begin
                errors++;
                $display("FAIL decoder_dir%0d got=%b expected=%b", i, alu_control, vec[i][2:0]);
            end
        end
        for (int i = 0; i < 200; i++) begin
            alu_op   = 2'($urandom);
            funct3   = 3'($urandom);
            op5      = 1'($urandom);
            funct7_5 = 1'($urandom);
            #1;
            exp_c = ref_ctrl(alu_op, funct3, op5, funct7_5);
            checks++;
            if (alu_control !== exp_c) begin
                errors++;
                $display("FAIL decoder_rand op=%b f3=%b o5=%b f7=%b got=%b expected=%b",
                         alu_op, funct3, op5, funct7_5, alu_control, exp_c);
            end
        end
    endtask

    task automatic test_alu();
        // {alu_op, funct3, op5f7, a, b, expected result}
        logic [102:0] vec [7];
        logic [2:0]  exp_c;
        logic [31:0] exp_r;
        vec[0] = {2'b00, 3'b000, 2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vec[1] = {2'b01, 3'b000, 2'b00, 32'd5,        32'd7,        32'hFFFFFFFE};
        vec[2] = {2'b10, 3'b010, 2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vec[3] = {2'b10, 3'b010, 2'b00, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        vec[4] = {2'b10, 3'b111, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        vec[5] = {2'b10, 3'b110, 2'b00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
        vec[6] = {2'b10, 3'b000, 2'b11, 32'd9,        32'd9,        32'h00000000};
        for (int i = 0; i < 7; i++) begin
            {alu_op, funct3, op5, funct7_5, src_a, src_b} = vec[i][102:32];
            #1;
            checks++;
            if (alu_result !== vec[i][31:0] || zero !== (vec[i][31:0] == 32'd0)) begin
                errors++;
                $display("FAIL alu_dir%0d res=%h zero=%b expected res=%h zero=%b",
                         i, alu_result, zero, vec[i][31:0], (vec[i][31:0] == 32'd0));
            end
        end
        for (int i = 0; i < 300; i++) begin
            alu_op   = 2'($urandom);
            funct3   = 3'($urandom);
            op5      = 1'($urandom);
            funct7_5 = 1'($urandom);
            src_a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            src_b    = ($urandom_range(0, 3) == 0) ? src_a : $urandom;
            #1;
            exp_c = ref_ctrl(alu_op, funct3, op5, funct7_5);
            exp_r = ref_alu(exp_c, src_a, src_b);
            checks++;
            if (alu_result !== exp_r || zero !== (exp_r == 32'd0)) begin
                errors++;
                $display("FAIL alu_rand ctrl=%b a=%h b=%h res=%h zero=%b expected res=%h",
                         exp_c, src_a, src_b, alu_result, zero, exp_r);
            end
        end
    endtask

    task automatic test_xor();
        logic [2:0]  exp_c;
        logic [31:0] exp_r;
        alu_op   = 2'b10;
        funct3   = 3'b100;
        op5      = 1'b0;
        funct7_5 = 1'b0;
        src_a    = 32'hFF00FF00;
        src_b    = 32'h0F0F0F0F;
`ifdef ALU_XOR_EN
        exp_c = 3'b100;
        exp_r = 32'hF00FF00F;
`else
        exp_c = 3'b000;
        exp_r = 32'h0E100E0F;
`endif
        #1;
        checks++;
        if (alu_control !== exp_c || alu_result !== exp_r) begin
            errors++;
            $display("FAIL xor_feature ctrl=%b res=%h expected ctrl=%b res=%h",
                     alu_control, alu_result, exp_c, exp_r);
        end
    endtask

    task automatic test_reset_vs_write();
        do_write(32'd12, 32'hA5A5A5A5);
        mem_adr = 32'd12;
        #1;
        checks++;
        if (mem_rd !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL pre_reset_data got=%h expected=a5a5a5a5", mem_rd);
        end
        @(negedge clk);
        reset   = 1'b1;
        mem_we  = 1'b1;
        mem_adr = 32'd12;
        mem_wd  = 32'h1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        @(negedge clk);
        reset  = 1'b0;
        mem_we = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_beats_write got=%h expected=00000000", mem_rd);
        end
        mem_adr = 32'd8;
        #1;
        checks++;
        if (mem_rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_clears_other got=%h expected=00000000", mem_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adr;
        for (int i = 0; i < 150; i++) begin
            adr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(adr, $urandom);
            end
            @(negedge clk);
            adr     = $urandom;
            mem_adr = adr;
            #1;
            checks++;
            if (mem_rd !== ref_mem[ref_idx(adr)]) begin
                errors++;
                $display("FAIL mem_rand adr=%h got=%h expected=%h", adr, mem_rd, ref_mem[ref_idx(adr)]);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        mem_we   = 1'b0;
        mem_adr  = 32'd0;
        mem_wd   = 32'd0;
        alu_op   = 2'b00;
        funct3   = 3'b000;
        op5      = 1'b0;
        funct7_5 = 1'b0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        test_reset();
        test_write_read();
        test_wrap();
        test_decoder();
        test_alu();
        test_xor();
        test_reset_vs_write();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
Execute/memory datapath slice of the 5-stage RV32I pipeline. It combines three parts:
- ALU control decoder: maps alu_op/funct3/op5/funct7_5 to a 3-bit ALU control code.
- 32-bit ALU: produces a result and a zero flag.
- Word-addressed data memory: synchronous write, combinational read.

ALU and decoder are purely combinational. Only the memory array holds state.

Parameters:
DEPTH, 64, number of 32-bit words in data memory (power of two, >=4)
ADDR_BITS, $clog2(DEPTH), word-index width, derived; not to be overridden

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears data memory
alu_op  input  2  00 load/store/jalr add, 01 branch sub, 10 R/I-type use funct3, 11 reserved
funct3  input  3  instruction bits [14:12]
op5  input  1  instruction bit [5] (1 = R-type)
funct7_5  input  1  instruction bit [30]
src_a  input  32  ALU operand A
src_b  input  32  ALU operand B
alu_control  output  3  decoded ALU operation
alu_result  output  32  ALU result
zero  output  1  1 when alu_result == 0
mem_we  input  1  data memory write enable
mem_adr  input  32  byte address
mem_wd  input  32  write data
mem_rd  output  32  read data

Behaviour:
Decoder (combinational):
- alu_op 00 -> 000 (add); 01 -> 001 (sub); 11 -> 000.
- alu_op 10, decoded by funct3:
  - 000: {op5,funct7_5}==11 -> 001 (sub), else 000 (add). So addi with bit30=1 is still add.
  - 010 -> 101 (slt).
  - 110 -> 011 (or).
  - 111 -> 010 (and).
  - any other funct3 -> 000.

ALU (combinational, driven by alu_control):
- 000: a+b, mod 2^32, carry discarded.
- 001: a-b, mod 2^32.
- 010: a&b.
- 011: a|b.
- 101: signed compare, result 32'd1 if $signed(a) < $signed(b), else 0.
- Any other code: result 0, hence zero=1.
- zero = (alu_result == 32'd0), valid for every code.

Data memory:
- Word index = mem_adr[ADDR_BITS+1:2]. Bits [1:0] are ignored, so accesses are word-aligned. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Read: mem_rd = mem[index], combinational, zero latency.
- Write: on rising clk with mem_we=1 and reset=0, mem[index] <= mem_wd.
- Same-cycle read of the address being written returns the old data; the new data is visible after the edge.
- Reset: on rising clk with reset=1, all DEPTH words become 0 in that single edge; a concurrent mem_we is ignored.
- After reset deasserts, mem_rd = 0 for every address.
- Reset mid-operation discards all stored data.
- Reset has no effect on the combinational outputs alu_control, alu_result and zero.
- Memory contents are undefined (X) before the first reset; the bench must reset first.

Outputs (reset values):
- mem_rd = 0 after reset, at any address.
- alu_control, alu_result, zero are pure functions of the current inputs at all times, including during reset.

Optional Feature:
ALU_XOR_EN
- Defined:
  - Decoder maps alu_op 10 with funct3 100 to control 100.
  - ALU control 100 computes a^b.
- Undefined:
  - funct3 100 decodes to 000 (add).
  - Control 100 yields result 0, like other unused codes.

Test Plan:
- Reset, then read addresses 0, 4, 252 -> mem_rd=0 each; write 32'hDEADBEEF at adr 8 -> mem_rd reads old 0 before the edge and 32'hDEADBEEF after it.
- Wrap/alignment, DEPTH=64: write 32'h12345678 at adr 32'h100 -> it lands in word 0, so reading adr 0 and adr 3 both return 32'h12345678.
- Decoder sweep:
  - alu_op=10, funct3=000, {op5,funct7_5}=11 -> alu_control=001; =01 -> 000.
  - alu_op=10, funct3=010 -> 101; funct3=110 -> 011; funct3=111 -> 010.
  - alu_op=01 -> 001; alu_op=00 -> 000.
- ALU arithmetic:
  - add 32'hFFFFFFFF+1 -> 0, zero=1.
  - sub 5-7 -> 32'hFFFFFFFE, zero=0.
  - slt a=32'hFFFFFFFF, b=1 -> 1; slt a=1, b=32'hFFFFFFFF -> 0.
  - and/or on 32'hF0F0F0F0 and 32'h0FF00FF0 -> 32'h00F000F0 / 32'hFFF0FFF0.
- Write 32'hA5A5A5A5 to adr 12, then assert reset together with mem_we=1, mem_wd=32'h1 at adr 12 -> after the edge mem_rd at adr 12 is 0.
- With ALU_XOR_EN: alu_op=10, funct3=100, a=32'hFF00FF00, b=32'h0F0F0F0F -> alu_control=100, result 32'hF00FF00F. Without it: alu_control=000, result 32'h0E100E0F.
